rand_index_select: RTL and testbench



---
 rtl/rand_sel_pkg.sv | 20 ++
 rtl/range_mask_gen.sv | 19 +
 rtl/rand_index_select.sv | 200 ++++++++++++++++++++
 tb/tb_rand_index_select.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_sel_pkg.sv
// Shared types and constants for rand_index_select and its helpers.
// Holds the FSM state encoding, default geometry and the try-counter width helper.
package rand_sel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } sel_state_e;

    localparam int DEF_IDX_W     = 12;
    localparam int DEF_MAX_TRIES = 8;
    localparam int FLIP_BITS     = 16;

    // Width of a counter that must hold 0..max_tries-1; never narrower than one bit.
    function automatic int try_cnt_w(input int max_tries);
        return (max_tries > 1) ? $clog2(max_tries) : 1;
    endfunction

endpackage

// File: rtl/range_mask_gen.sv
// Turns an exclusive bound into the smallest all-ones mask covering limit-1.
// Purely combinational so any bounded-random consumer can reuse it.
// limit = 1 yields mask 0; limit = 0 yields all ones (callers treat 0 as an error).
module range_mask_gen #(
    parameter int IDX_W = 12
) (
    input  logic [IDX_W-1:0] limit,
    output logic [IDX_W-1:0] mask
);

    // Leading-one fill of limit-1: smear the top set bit into every lower position.
    always_comb begin
        mask = limit - IDX_W'(1);
        for (int s = 1; s < IDX_W; s = s * 2) begin
            mask = mask | (mask >> s);
        end
    end

endmodule

// File: rtl/rand_index_select.sv
// Uniform index in [0, limit) plus a biased coin flip from a free-running PRNG word.
// Rejection sampling with a bounded number of draws, then a deterministic fallback
// (cand - limit) so the result always appears within MAX_TRIES+1 cycles of accept.
// Optional statistics counters are compiled in with RAND_INDEX_SELECT_STATS_EN.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both
// high. req_ready is high only in IDLE. Once out_valid rises it stays high, with idx,
// flip, fallback and err frozen, until the edge where out_ready is also high.
module rand_index_select
    import rand_sel_pkg::*;
#(
    parameter int IDX_W     = DEF_IDX_W,
    parameter int MAX_TRIES = DEF_MAX_TRIES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      rand_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] limit,
    input  logic [15:0]      noise_thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] idx,
    output logic             flip,
    output logic             fallback,
    output logic             err,
`ifdef RAND_INDEX_SELECT_STATS_EN
    output logic [31:0]      stat_rejects,
    output logic [15:0]      stat_fallbacks,
`endif
    output logic [1:0]       dbg_state
);

    localparam int              TRY_W    = try_cnt_w(MAX_TRIES);
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    sel_state_e             state_q, state_d;
    logic [IDX_W-1:0]       limit_q, limit_d;
    logic [FLIP_BITS-1:0]   thresh_q, thresh_d;
    logic [IDX_W-1:0]       mask_q, mask_d;
    logic [TRY_W-1:0]       try_q, try_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   flip_q, flip_d;
    logic                   fallback_q, fallback_d;
    logic                   err_q, err_d;
    logic                   valid_q, valid_d;

    logic [IDX_W-1:0]       mask_w;
    logic [IDX_W-1:0]       cand;
    logic                   draw_flip;
    logic                   reject_hit;
    logic                   fallback_hit;
    logic                   unused_rand;

    // Only the low IDX_W bits and the top FLIP_BITS bits of the PRNG word matter.
    assign unused_rand = ^rand_in;

    range_mask_gen #(.IDX_W(IDX_W)) u_mask (
        .limit (limit),
        .mask  (mask_w)
    );

    // Next-state and datapath decisions for the IDLE -> DRAW -> HOLD loop.
    always_comb begin
        state_d      = state_q;
        limit_d      = limit_q;
        thresh_d     = thresh_q;
        mask_d       = mask_q;
        try_d        = try_q;
        idx_d        = idx_q;
        flip_d       = flip_q;
        fallback_d   = fallback_q;
        err_d        = err_q;
        valid_d      = valid_q;
        reject_hit   = 1'b0;
        fallback_hit = 1'b0;
        cand         = rand_in[IDX_W-1:0] & mask_q;
        draw_flip    = (rand_in[31:32-FLIP_BITS] < thresh_q);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    limit_d  = limit;
                    thresh_d = noise_thresh;
                    mask_d   = mask_w;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                if (limit_q == '0) begin
                    idx_d      = '0;
                    flip_d     = 1'b0;
                    fallback_d = 1'b0;
                    err_d      = 1'b1;
                    valid_d    = 1'b1;
                    state_d    = HOLD;
                end else if (cand < limit_q) begin
                    idx_d      = cand;
                    flip_d     = draw_flip;
                    fallback_d = 1'b0;
                    err_d      = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = HOLD;
                end else begin
                    reject_hit = 1'b1;
                    if (try_q == LAST_TRY) begin
                        // mask_q < 2*limit_q, so this difference is already in range.
                        idx_d        = cand - limit_q;
                        flip_d       = draw_flip;
                        fallback_d   = 1'b1;
                        err_d        = 1'b0;
                        valid_d      = 1'b1;
                        fallback_hit = 1'b1;
                        state_d      = HOLD;
                    end else begin
                        try_d = try_q + TRY_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    try_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register all state; reset discards any request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            limit_q    <= '0;
            thresh_q   <= '0;
            mask_q     <= '0;
            try_q      <= '0;
            idx_q      <= '0;
            flip_q     <= 1'b0;
            fallback_q <= 1'b0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            thresh_q   <= thresh_d;
            mask_q     <= mask_d;
            try_q      <= try_d;
            idx_q      <= idx_d;
            flip_q     <= flip_d;
            fallback_q <= fallback_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
        end
    end

`ifdef RAND_INDEX_SELECT_STATS_EN
    logic [31:0] stat_rej_q, stat_rej_d;
    logic [15:0] stat_fb_q, stat_fb_d;

    // Saturating event counters for rejected draws and fallback completions.
    always_comb begin
        stat_rej_d = stat_rej_q;
        stat_fb_d  = stat_fb_q;
        if (reject_hit && (stat_rej_q != '1)) begin
            stat_rej_d = stat_rej_q + 32'd1;
        end
        if (fallback_hit && (stat_fb_q != '1)) begin
            stat_fb_d = stat_fb_q + 16'd1;
        end
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_rej_q <= '0;
            stat_fb_q  <= '0;
        end else begin
            stat_rej_q <= stat_rej_d;
            stat_fb_q  <= stat_fb_d;
        end
    end

    assign stat_rejects   = stat_rej_q;
    assign stat_fallbacks = stat_fb_q;
`endif

    assign req_ready = (state_q == IDLE);
    assign out_valid = valid_q;
    assign idx       = idx_q;
    assign flip      = flip_q;
    assign fallback  = fallback_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rand_index_select.sv
// Bench for rand_index_select: the driver pushes an expected result (arrival cycle,
// idx, flip, fallback, err) computed by a reference model from the PRNG words it
// will present; a monitor pops and compares whenever a result appears.
`timescale 1ns/1ps
module tb_rand_index_select;

    localparam int IW = 12;
    localparam int MT = 4;
    localparam int W  = 40;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [31:0]   rand_in = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [IW-1:0] limit = '0;
    logic [15:0]   noise_thresh = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] idx;
    logic          flip, fallback, err;
    logic [1:0]    dbg_state;
`ifdef RAND_INDEX_SELECT_STATS_EN
    logic [31:0]   stat_rejects;
    logic [15:0]   stat_fallbacks;
`endif

    rand_index_select #(.IDX_W(IW), .MAX_TRIES(MT)) dut (
        .clk          (clk),
        .reset        (reset),
        .rand_in      (rand_in),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .limit        (limit),
        .noise_thresh (noise_thresh),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .idx          (idx),
        .flip         (flip),
        .fallback     (fallback),
        .err          (err),
`ifdef RAND_INDEX_SELECT_STATS_EN
        .stat_rejects   (stat_rejects),
        .stat_fallbacks (stat_fallbacks),
`endif
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    longint exp_rejects   = 0;
    longint exp_fallbacks = 0;

    function automatic void check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // PRNG words presented in draw cycles 1..MT of the next request.
    logic [31:0] plan [MT];

    // Reference: mask is the smallest 2^k-1 not below limit-1; draw until a candidate
    // lands under limit, else subtract limit from the last candidate.
    task automatic model(input int lim, input int thr, output int draws, output int e_idx,
                         output bit e_flip, output bit e_fb, output bit e_err);
        int m, cand, hi;
        e_idx = 0; e_flip = 0; e_fb = 0; e_err = 0; draws = 1;
        if (lim == 0) begin
            e_err = 1;
            return;
        end
        m = 0;
        while (m < lim - 1) m = 2 * m + 1;
        for (int i = 0; i < MT; i++) begin
            cand  = int'(plan[i][IW-1:0]) & m;
            hi    = int'(plan[i][31:16]);
            draws = i + 1;
            if (cand < lim) begin
                e_idx  = cand;
                e_flip = (hi < thr);
                return;
            end
            if (i == MT - 1) begin
                e_idx  = cand - lim;
                e_flip = (hi < thr);
                e_fb   = 1;
                return;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    int stall_len = 0;

    task automatic wait_idle();
        int guard = 0;
        while (!req_ready && guard < 100) begin
            rand_in = $urandom;
            @(posedge clk); #1;
            guard++;
        end
        if (!req_ready) check("req_ready_timeout", 0, 1);
    endtask

    task automatic do_req(input int lim, input int thr, input int stall);
        int draws, e_idx;
        bit e_flip, e_fb, e_err;
        wait_idle();
        model(lim, thr, draws, e_idx, e_flip, e_fb, e_err);
        exp_q.push_back({16'(cyc + 1 + draws), 16'(e_idx), 5'b0, e_flip, e_fb, e_err});
        if (!e_err) exp_rejects += (e_fb ? draws : draws - 1);
        if (e_fb) exp_fallbacks += 1;
        stall_len    = stall;
        req_valid    = 1'b1;
        limit        = IW'(lim);
        noise_thresh = 16'(thr);
        rand_in      = $urandom;
        @(posedge clk); #1;
        req_valid    = 1'b0;
        limit        = IW'($urandom);
        noise_thresh = 16'($urandom);
        for (int i = 0; i < MT; i++) begin
            rand_in = plan[i];
            @(posedge clk); #1;
        end
        rand_in = $urandom;
    endtask

    task automatic fill_low(input int low, input int hi16);
        for (int i = 0; i < MT; i++) begin
            plan[i] = {16'(hi16 < 0 ? $urandom : hi16), 4'($urandom), 12'(low)};
        end
    endtask

    // Accept a request that keeps rejecting, then reset mid-draw: nothing is produced.
    task automatic reset_mid_draw();
        wait_idle();
        fill_low(7, -1);
        req_valid    = 1'b1;
        limit        = IW'(5);
        noise_thresh = 16'h8000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rand_in   = plan[0];
        @(posedge clk); #1;
        rand_in = plan[1];
        reset   = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rejects   = 0;
        exp_fallbacks = 0;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_req_ready", req_ready, 1);
        check("rst_mid_state", dbg_state, 0);
        check("rst_mid_idx", idx, 0);
    endtask

    // ---------------- consumer ----------------
    int vcnt = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (out_valid) vcnt++;
            else vcnt = 0;
            out_ready = (vcnt > stall_len);
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic          prev_valid = 1'b0;
        logic          prev_ready = 1'b0;
        logic [IW-1:0] prev_idx = '0;
        logic          prev_flip = 1'b0, prev_fb = 1'b0, prev_err = 1'b0;
        logic [W-1:0]  e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (out_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("arrival_cycle", cyc, e[39:24]);
                        check("idx", idx, e[23:8]);
                        check("flip", flip, e[2]);
                        check("fallback", fallback, e[1]);
                        check("err", err, e[0]);
                        check("req_ready_busy", req_ready, 0);
                    end
                end else if (out_valid && prev_valid && !prev_ready) begin
                    check("hold_idx", idx, prev_idx);
                    check("hold_flip", flip, prev_flip);
                    check("hold_fallback", fallback, prev_fb);
                    check("hold_err", err, prev_err);
                    check("hold_req_ready", req_ready, 0);
                end else if (out_valid && prev_valid && prev_ready) begin
                    check("valid_clear_after_handshake", 1, 0);
                end else if (!out_valid && prev_valid && !prev_ready) begin
                    check("valid_dropped_without_ready", 0, 1);
                end else if (!out_valid && prev_valid && prev_ready) begin
                    check("idle_after_handshake", req_ready, 1);
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_idx   = idx;
            prev_flip  = flip;
            prev_fb    = fallback;
            prev_err   = err;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        repeat (20000) @(posedge clk);
        check("watchdog_timeout", 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int lim, thr, guard;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_idx", idx, 0);
        check("rst_flip", flip, 0);
        check("rst_fallback", fallback, 0);
        check("rst_err", err, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_state", dbg_state, 0);

        // Accept on the third draw, consumer stalls three cycles.
        plan[0] = {16'($urandom), 16'h0006};
        plan[1] = {16'($urandom), 16'h0007};
        plan[2] = {16'h7FFF, 16'h0003};
        plan[3] = $urandom;
        do_req(5, 16'h8000, 3);

        // Every draw rejected: fallback 7 - 5 = 2.
        fill_low(7, -1);
        do_req(5, $urandom_range(0, 65535), 0);

        // limit 0 reports an error.
        fill_low($urandom_range(0, 4095), -1);
        do_req(0, 16'hFFFF, 1);

        // limit 1 always gives 0; threshold 0 never flips.
        fill_low($urandom_range(0, 4095), -1);
        do_req(1, 0, 0);

        // Threshold 0xFFFF flips except when the top half is 0xFFFF.
        fill_low(1, 16'hFFFF);
        do_req(4, 16'hFFFF, 0);
        fill_low(1, 16'hFFFE);
        do_req(4, 16'hFFFF, 2);

        // Widest bound.
        fill_low(4095, -1);
        do_req(4095, 16'h1234, 0);

        reset_mid_draw();
        fill_low(2, -1);
        do_req(3, $urandom_range(0, 65535), 0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: lim = $urandom_range(0, 8);
                1: lim = $urandom_range(0, 4095);
                2: lim = 1 << $urandom_range(0, 11);
                default: lim = (1 << $urandom_range(1, 10)) + 1;
            endcase
            case ($urandom_range(0, 3))
                0: thr = 0;
                1: thr = 16'hFFFF;
                default: thr = $urandom_range(0, 65535);
            endcase
            for (int i = 0; i < MT; i++) plan[i] = $urandom;
            do_req(lim, thr, $urandom_range(0, 3));
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("final_req_ready", req_ready, 1);
`ifdef RAND_INDEX_SELECT_STATS_EN
        check("stat_rejects", stat_rejects, exp_rejects);
        check("stat_fallbacks", stat_fallbacks, exp_fallbacks);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
